// File: rtl/seq_detector_param_if.sv
// Serial-input and result bundle of the parametrised sequence detector.
interface seq_detector_param_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
);
  logic               load;
  logic [MAX_LEN-1:0] pattern_in;
  logic [LEN_W-1:0]   len_in;
  logic               overlap_in;
  logic               valid;
  logic               x;
  logic               y;
  logic [CNT_W-1:0]   match_count;

  modport master (
    output load, pattern_in, len_in, overlap_in, valid, x,
    input  y, match_count
  );

  modport slave (
    input  load, pattern_in, len_in, overlap_in, valid, x,
    output y, match_count
  );
endinterface

// File: rtl/seq_detector_param.sv
// Programmable 1..MAX_LEN-bit serial pattern detector with registered Moore flag.
// Define SEQDET_COUNT_EN to build the saturating match counter; otherwise match_count reads 0.
module seq_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input logic                clk,
  input logic                reset,
  seq_detector_param_if.slave bus
);

  localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [MAX_LEN-1:0] hist_n_s;
  logic [MAX_LEN-1:0] mask_s;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [LEN_W-1:0]   fill_n_s;
  logic               ovl_q, ovl_d;
  logic               y_q, y_d;
  logic               accept_s;
  logic               match_s;

  // Match evaluation on the bit currently presented
  always_comb begin
    accept_s = bus.valid & ~bus.load;
    hist_n_s = {hist_q[MAX_LEN-2:0], bus.x};
    if (fill_q >= MAX_LEN_C) begin
      fill_n_s = MAX_LEN_C;
    end else begin
      fill_n_s = fill_q + LEN_W'(1);
    end
    mask_s = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask_s[i] = (LEN_W'(i) < len_q);
    end
    match_s = (len_q != '0) && (fill_n_s >= len_q) &&
              (((hist_n_s ^ pat_q) & mask_s) == '0);
  end

  // Next-state for configuration and detector state; load outranks an accepted bit
  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    hist_d = hist_q;
    fill_d = fill_q;
    y_d    = y_q;
    if (bus.load) begin
      pat_d  = bus.pattern_in;
      len_d  = (bus.len_in > MAX_LEN_C) ? MAX_LEN_C : bus.len_in;
      ovl_d  = bus.overlap_in;
      hist_d = '0;
      fill_d = '0;
      y_d    = 1'b0;
    end else if (accept_s) begin
      hist_d = hist_n_s;
      y_d    = match_s;
      // Non-overlapping detection restarts the fill so the next match needs len fresh bits
      if (match_s && !ovl_q) begin
        fill_d = '0;
      end else begin
        fill_d = fill_n_s;
      end
    end else begin
      y_d = y_q;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q  <= '0;
      len_q  <= MAX_LEN_C;
      ovl_q  <= 1'b0;
      hist_q <= '0;
      fill_q <= '0;
      y_q    <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      y_q    <= y_d;
    end
  end

  assign bus.y = y_q;

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating match counter
  always_comb begin
    cnt_d = cnt_q;
    if (bus.load) begin
      cnt_d = '0;
    end else if (accept_s && match_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.match_count = cnt_q;
`else
  assign bus.match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed self-checking bench for seq_detector_param (main instance plus a CNT_W=2 instance).
module tb_seq_detector_param;

`ifdef SEQDET_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  seq_detector_param_if #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) bus ();
  seq_detector_param_if #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) sbus ();

  seq_detector_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  seq_detector_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .bus(sbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] p, input logic [3:0] l, input logic o);
    @(negedge clk);
    bus.load       = 1'b1;
    bus.pattern_in = p;
    bus.len_in     = l;
    bus.overlap_in = o;
    bus.valid      = 1'b0;
    @(posedge clk);
    #1;
    bus.load = 1'b0;
  endtask

  task automatic send(input logic b, input logic v);
    @(negedge clk);
    bus.valid = v;
    bus.x     = b;
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (bus.y !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_y got %b exp 0", bus.y);
    end
    vectors++;
    if (bus.match_count !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_count got %0d exp 0", bus.match_count);
    end
  endtask

  task automatic test_basic();
    logic [11:0] s;
    logic [11:0] e;
    s = 12'b110101110101;
    e = 12'b000001000001;
    do_load(8'b00110101, 4'd6, 1'b0);
    for (int i = 11; i >= 0; i--) begin
      send(s[i], 1'b1);
      vectors++;
      if (bus.y !== e[i]) begin
        miscompares++;
        $display("FAIL basic_y bit%0d got %b exp %b", 12 - i, bus.y, e[i]);
      end
    end
    vectors++;
    if (bus.match_count !== (CNT_ON ? 8'd2 : 8'd0)) begin
      miscompares++;
      $display("FAIL basic_count got %0d exp %0d", bus.match_count, CNT_ON ? 2 : 0);
    end
  endtask

  task automatic test_overlap(input logic o);
    logic [7:0] s;
    logic [7:0] e;
    s = 8'b10101010;
    e = o ? 8'b00010101 : 8'b00010001;
    do_load(8'b00001010, 4'd4, o);
    for (int i = 7; i >= 0; i--) begin
      send(s[i], 1'b1);
      vectors++;
      if (bus.y !== e[i]) begin
        miscompares++;
        $display("FAIL overlap%0d_y bit%0d got %b exp %b", o, 8 - i, bus.y, e[i]);
      end
    end
    vectors++;
    if (bus.match_count !== (CNT_ON ? (o ? 8'd3 : 8'd2) : 8'd0)) begin
      miscompares++;
      $display("FAIL overlap%0d_count got %0d exp %0d", o, bus.match_count,
               CNT_ON ? (o ? 3 : 2) : 0);
    end
  endtask

  task automatic test_valid_gaps();
    logic [5:0] s;
    logic [5:0] e;
    s = 6'b110101;
    e = 6'b000001;
    do_load(8'b00110101, 4'd6, 1'b0);
    for (int i = 5; i >= 0; i--) begin
      if (i == 2) begin
        for (int g = 0; g < 3; g++) begin
          send(1'b0, 1'b0);
          vectors++;
          if (bus.y !== 1'b0) begin
            miscompares++;
            $display("FAIL gap_pre_y cycle%0d got %b exp 0", g, bus.y);
          end
        end
      end
      send(s[i], 1'b1);
      vectors++;
      if (bus.y !== e[i]) begin
        miscompares++;
        $display("FAIL gap_y bit%0d got %b exp %b", 6 - i, bus.y, e[i]);
      end
    end
    for (int g = 0; g < 2; g++) begin
      send(1'b0, 1'b0);
      vectors++;
      if (bus.y !== 1'b1) begin
        miscompares++;
        $display("FAIL gap_hold_y cycle%0d got %b exp 1", g, bus.y);
      end
    end
    send(1'b0, 1'b1);
    vectors++;
    if (bus.y !== 1'b0) begin
      miscompares++;
      $display("FAIL gap_drop_y got %b exp 0", bus.y);
    end
  endtask

  task automatic test_len_zero();
    do_load(8'b00000000, 4'd0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      send(1'b0, 1'b1);
      vectors++;
      if (bus.y !== 1'b0) begin
        miscompares++;
        $display("FAIL len0_y bit%0d got %b exp 0", i + 1, bus.y);
      end
    end
    vectors++;
    if (bus.match_count !== 8'd0) begin
      miscompares++;
      $display("FAIL len0_count got %0d exp 0", bus.match_count);
    end
  endtask

  task automatic test_len_clamp();
    logic [8:0] s;
    logic [8:0] e;
    s = 9'b010110011;
    e = 9'b000000001;
    do_load(8'b10110011, 4'd15, 1'b1);
    for (int i = 8; i >= 0; i--) begin
      send(s[i], 1'b1);
      vectors++;
      if (bus.y !== e[i]) begin
        miscompares++;
        $display("FAIL clamp_y bit%0d got %b exp %b", 9 - i, bus.y, e[i]);
      end
    end
    vectors++;
    if (bus.match_count !== (CNT_ON ? 8'd1 : 8'd0)) begin
      miscompares++;
      $display("FAIL clamp_count got %0d exp %0d", bus.match_count, CNT_ON ? 1 : 0);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_c;
    @(negedge clk);
    sbus.load       = 1'b1;
    sbus.pattern_in = 8'b00000001;
    sbus.len_in     = 4'd1;
    sbus.overlap_in = 1'b0;
    sbus.valid      = 1'b0;
    @(posedge clk);
    #1;
    sbus.load = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      sbus.valid = 1'b1;
      sbus.x     = 1'b1;
      @(posedge clk);
      #1;
      sbus.valid = 1'b0;
      exp_c = CNT_ON ? ((i > 3) ? 2'd3 : 2'(i)) : 2'd0;
      vectors++;
      if (sbus.y !== 1'b1) begin
        miscompares++;
        $display("FAIL sat_y match%0d got %b exp 1", i, sbus.y);
      end
      vectors++;
      if (sbus.match_count !== exp_c) begin
        miscompares++;
        $display("FAIL sat_count match%0d got %0d exp %0d", i, sbus.match_count, exp_c);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] s;
    s = 5'b11010;
    do_load(8'b00110101, 4'd6, 1'b0);
    for (int i = 4; i >= 0; i--) begin
      send(s[i], 1'b1);
    end
    do_reset();
    vectors++;
    if (bus.y !== 1'b0 || bus.match_count !== 8'd0) begin
      miscompares++;
      $display("FAIL rstmid_state got y=%b cnt=%0d exp y=0 cnt=0", bus.y, bus.match_count);
    end
    send(1'b1, 1'b1);
    vectors++;
    if (bus.y !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_y got %b exp 0", bus.y);
    end
    // Reset config is pat=0, len=8: eight zeros after the 1 complete a match
    for (int i = 1; i <= 8; i++) begin
      send(1'b0, 1'b1);
      vectors++;
      if (bus.y !== (i == 8)) begin
        miscompares++;
        $display("FAIL rstcfg_y zero%0d got %b exp %b", i, bus.y, (i == 8));
      end
    end
  endtask

  task automatic test_load_with_valid();
    do_load(8'b00000001, 4'd1, 1'b0);
    send(1'b1, 1'b1);
    vectors++;
    if (bus.y !== 1'b1 || bus.match_count !== (CNT_ON ? 8'd1 : 8'd0)) begin
      miscompares++;
      $display("FAIL ldv_pre got y=%b cnt=%0d exp y=1 cnt=%0d", bus.y, bus.match_count,
               CNT_ON ? 1 : 0);
    end
    @(negedge clk);
    bus.load       = 1'b1;
    bus.pattern_in = 8'b00000001;
    bus.len_in     = 4'd1;
    bus.overlap_in = 1'b0;
    bus.valid      = 1'b1;
    bus.x          = 1'b1;
    @(posedge clk);
    #1;
    bus.load  = 1'b0;
    bus.valid = 1'b0;
    vectors++;
    if (bus.y !== 1'b0 || bus.match_count !== 8'd0) begin
      miscompares++;
      $display("FAIL ldv_discard got y=%b cnt=%0d exp y=0 cnt=0", bus.y, bus.match_count);
    end
    send(1'b1, 1'b1);
    vectors++;
    if (bus.y !== 1'b1 || bus.match_count !== (CNT_ON ? 8'd1 : 8'd0)) begin
      miscompares++;
      $display("FAIL ldv_post got y=%b cnt=%0d exp y=1 cnt=%0d", bus.y, bus.match_count,
               CNT_ON ? 1 : 0);
    end
  endtask

  initial begin
    vectors         = 0;
    miscompares     = 0;
    reset           = 1'b1;
    bus.load        = 1'b0;
    bus.pattern_in  = 8'd0;
    bus.len_in      = 4'd0;
    bus.overlap_in  = 1'b0;
    bus.valid       = 1'b0;
    bus.x           = 1'b0;
    sbus.load       = 1'b0;
    sbus.pattern_in = 8'd0;
    sbus.len_in     = 4'd0;
    sbus.overlap_in = 1'b0;
    sbus.valid      = 1'b0;
    sbus.x          = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_basic();
    test_overlap(1'b1);
    test_overlap(1'b0);
    test_valid_gaps();
    test_len_zero();
    test_len_clamp();
    test_saturation();
    test_reset_mid();
    test_load_with_valid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial sequence detector, the next generation of the fixed-pattern Moore detectors in the mini-project. It detects a run-time programmable bit pattern of 1..MAX_LEN bits in a serial stream. It supports overlapping and non-overlapping detection modes and qualifies input bits with a valid strobe. It exposes a registered Moore match flag and a saturating match counter, and sits directly on the serial input path of the design.

## Interface
- MAX_LEN, default 8: maximum pattern length in bits (≥2).
- LEN_W, default 4: width of the length field; must hold the value MAX_LEN.
- CNT_W, default 8: match counter width.

- clk  in  1  sole clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- load  in  1  one-cycle pulse; latches pattern_in, len_in and overlap_in, and clears detector state.
- pattern_in  in  MAX_LEN  pattern bits; bit [len-1] is the first bit received, bit [0] the last.
- len_in  in  LEN_W  pattern length.
- overlap_in  in  1  1 = overlapping detection, 0 = non-overlapping.
- valid  in  1  x is sampled only when valid=1.
- x  in  1  serial data bit.
- y  out  1  Moore match flag (registered).
- match_count  out  CNT_W  saturating count of detections.

## Operation
- Configuration registers: pat, len, ovl.
  - Reset values: pat=0, len=MAX_LEN, ovl=0.
  - Written only on load.
  - len_in=0 is stored as 0 and means matching is disabled.
  - len_in>MAX_LEN is clamped to MAX_LEN.
- Datapath registers: history shift register hist[MAX_LEN-1:0], fill counter (0..MAX_LEN), y, match_count.
- Accepted bit (valid=1, load=0, reset=0):
  - hist_n = {hist[MAX_LEN-2:0], x}.
  - fill_n = min(fill+1, MAX_LEN).
  - Match when len≠0, fill_n≥len, and hist_n[len-1:0]==pat[len-1:0]. Bits above len are ignored.
- On a match:
  - y←1.
  - match_count increments, saturating at all-ones; it never wraps.
  - Non-overlapping mode (ovl=0): fill←0. The next match requires len fresh bits.
  - Overlapping mode (ovl=1): fill is kept, so bits are shared between matches.
- On an accepted bit that does not match: y←0.
- Cycle with valid=0: hist, fill and y all hold. y is a state output and stays constant until the next accepted bit.
- Load: hist←0, fill←0, y←0, match_count←0, and the new configuration is latched. If valid=1 in the same cycle, load wins and that bit is discarded.
- Reset:
  - Sets all registers to their reset values: y=0, match_count=0, hist=0, fill=0, plus the configuration values above.
  - Has priority over load and valid.
  - Asserted mid-sequence, it abandons any partial match.

## Timing
- Latency: y rises in the first cycle after the clock edge that samples the completing bit. y and match_count update together.
- y stays high until the next accepted bit. Back-to-back matches in overlapping mode keep y=1 across consecutive accepted bits.
- The first match is possible only after len accepted bits following reset or load.
- No combinational path exists from any input to any output.

## Configuration
- SEQDET_COUNT_EN defined: the CNT_W-bit match counter is built as described above.
- SEQDET_COUNT_EN undefined: no counter register is built, match_count is tied to 0, and y behaviour is unchanged.

## Test plan
- Basic non-overlap:
  - Stimulus: load pattern=6'b110101, len=6, ovl=0; stream 110101110101 with valid=1 continuously.
  - Response: y=1 after bits 6 and 12 only; match_count=2.
- Overlap versus non-overlap:
  - Stimulus: load pattern=1010, len=4; stream 10101010.
  - Response with ovl=1: y=1 after bits 4, 6 and 8; count=3.
  - Response with ovl=0: y=1 after bits 4 and 8; count=2.
- Valid gaps:
  - Stimulus: pattern 110101 with valid deasserted for 3 cycles between bits 3 and 4.
  - Response: detection still occurs after the 6th accepted bit, and y holds its value during the gaps.
- Boundaries:
  - len=0: no match on any stream; count stays 0.
  - len=15 (clamped to 8): behaves as len=8.
  - Saturation: with CNT_W=2 and 5 matches, count stops at 3.
- Reset and load mid-sequence:
  - Stimulus: after bits 11010, assert reset for 1 cycle, then send 1.
  - Response: no match.
  - Stimulus: assert load together with valid=1.
  - Response: that bit is discarded, and y=0 and count=0 in the next cycle.
- Macro off:
  - Stimulus: build without SEQDET_COUNT_EN and run the basic non-overlap scenario.
  - Response: y pulses as in that scenario, and match_count stays 0.
